// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-port register file slice.
//   rf_state_t     : sequencer state (INIT while the clear sweep runs, READY after)
//   DEF_WORD_W     : default data width per entry
//   DEF_RF_SIZE    : default number of entries
//   DEF_NUM_RD     : default read port count
//   DEF_NUM_WR     : default write port count
package regfile_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } rf_state_t;

  localparam int DEF_WORD_W  = 32;
  localparam int DEF_RF_SIZE = 32;
  localparam int DEF_NUM_RD  = 3;
  localparam int DEF_NUM_WR  = 2;

endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq
// Post-reset clear sequencer. After rst falls it walks an address counter
// from 0 to RF_SIZE-1, asking the array to zero one entry per cycle, and
// then declares the register file ready.
// Ports:
//   clk      in   clock, all state on posedge
//   rst      in   synchronous active-high reset, restarts the sweep
//   clr_en   out  zero the entry at clr_addr on this edge
//   clr_addr out  entry currently being cleared
//   ready    out  high once every entry has been cleared
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int RF_SIZE = DEF_RF_SIZE,
  parameter int ADDR_W  = $clog2(RF_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RF_SIZE - 1);

  rf_state_t         state;
  rf_state_t         state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  // State and sweep counter registers. Reset parks the sequencer at the
  // start of the sweep regardless of where it was, so a reset in READY or
  // mid-sweep both restart clearing from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and output decode. The clear strobe is suppressed while rst
  // is high so that reset edges never disturb the array contents.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_en    = 1'b0;
    ready     = 1'b0;
    case (state)
      INIT: begin
        clr_en  = ~rst;
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == LAST_ADDR) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end
      end
      READY: begin
        ready = 1'b1;
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised multi-port register file: NUM_RD combinational read ports,
// NUM_WR synchronous write ports with highest-index-wins collision priority,
// a post-reset clear sweep and a registered write-conflict report.
// Optional feature macro: REGFILE_BYPASS_EN - when defined, a read whose
// address matches a valid write in the same cycle returns that write data.
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   re            in   per-port read enable            [NUM_RD]
//   ra            in   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd            out  read data, port i at [i*WORD_W +: WORD_W]
//   we            in   per-port write enable           [NUM_WR]
//   wa            in   write addresses, packed as ra
//   wd            in   write data, packed as rd
//   ready         out  clear sweep complete
//   wr_conflict   out  pulse: enabled writes collided on the previous edge
//   conflict_addr out  address of the most recent collision
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  WORD_W   = DEF_WORD_W,
  parameter int  RF_SIZE  = DEF_RF_SIZE,
  parameter int  NUM_RD   = DEF_NUM_RD,
  parameter int  NUM_WR   = DEF_NUM_WR,
  parameter int  ZERO_REG = 0,
  localparam int ADDR_W   = $clog2(RF_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*WORD_W-1:0] rd,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*WORD_W-1:0] wd,
  output logic                     ready,
  output logic                     wr_conflict,
  output logic [ADDR_W-1:0]        conflict_addr
);

  localparam logic [ADDR_W:0] SIZE_EXT = (ADDR_W + 1)'(RF_SIZE);

  logic [WORD_W-1:0] mem [RF_SIZE];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic [NUM_WR-1:0] wvalid;
  logic              conf_any;
  logic [ADDR_W-1:0] conf_addr;

  // An address is usable when it lies inside the array and is not the
  // hardwired zero entry.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < SIZE_EXT) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  regfile_init_seq #(
    .RF_SIZE (RF_SIZE),
    .ADDR_W  (ADDR_W)
  ) u_init (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // A write port is live only once the sweep is done, outside reset edges,
  // and for a usable address. Everything downstream (array update, conflict
  // detection, bypass) keys off this one qualifier so they cannot disagree.
  always_comb begin
    wvalid = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wvalid[j] = we[j] && ready && !rst && addr_ok(wa[j*ADDR_W +: ADDR_W]);
    end
  end

  // Array update. During the sweep only the clear path writes. In READY the
  // ports are applied in ascending index order so the highest-index port
  // to a shared address is the last assignment and therefore wins.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wvalid[j]) begin
          mem[wa[j*ADDR_W +: ADDR_W]] <= wd[j*WORD_W +: WORD_W];
        end
      end
    end
  end

  // Collision detection across every pair of live write ports. The outer
  // loop runs upward over the higher port of each pair, so the reported
  // address ends up being that of the highest-index port involved in any
  // collision, which is also the winner at its address.
  always_comb begin
    conf_any  = 1'b0;
    conf_addr = '0;
    for (int k = 1; k < NUM_WR; k++) begin
      for (int j = 0; j < k; j++) begin
        if (wvalid[j] && wvalid[k] &&
            (wa[j*ADDR_W +: ADDR_W] == wa[k*ADDR_W +: ADDR_W])) begin
          conf_any  = 1'b1;
          conf_addr = wa[k*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // Registered conflict report. The pulse lasts one cycle; the address is
  // sticky until the next collision overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_conflict   <= 1'b0;
      conflict_addr <= '0;
    end else begin
      wr_conflict <= conf_any;
      if (conf_any) begin
        conflict_addr <= conf_addr;
      end
    end
  end

  // Read muxes. Ports return zero while the sweep runs, when disabled, or
  // for unusable addresses. With bypass enabled, live writes to the same
  // address override the array value, highest write index last so it wins.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ready && re[i] && addr_ok(ra[i*ADDR_W +: ADDR_W])) begin
        rd[i*WORD_W +: WORD_W] = mem[ra[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (wvalid[j] && (wa[j*ADDR_W +: ADDR_W] == ra[i*ADDR_W +: ADDR_W])) begin
            rd[i*WORD_W +: WORD_W] = wd[j*WORD_W +: WORD_W];
          end
        end
`else
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Self-checking bench for regfile_mp (RF_SIZE=20, three read and three
// write ports, ZERO_REG=1). A behavioural model of the register file is
// compared against the DUT on every falling edge; directed sequences pin
// the model with literal expectations, then random traffic follows.
// Honours REGFILE_BYPASS_EN in the same way as the design.
module tb_regfile_mp;

  localparam int WW = 16;
  localparam int RS = 20;
  localparam int NR = 3;
  localparam int NW = 3;
  localparam int ZR = 1;
  localparam int AW = $clog2(RS);

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] ra;
  logic [NR*WW-1:0] rd;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wa;
  logic [NW*WW-1:0] wd;
  logic             ready;
  logic             wr_conflict;
  logic [AW-1:0]    conflict_addr;

  int checks = 0;
  int errors = 0;

  int          since   = 0;
  bit          started = 1'b0;
  logic [WW-1:0] mdl [RS];
  logic        m_conf  = 1'b0;
  logic [AW-1:0] m_caddr = '0;
  bit          c_found;
  int          c_addr;

  regfile_mp #(
    .WORD_W   (WW),
    .RF_SIZE  (RS),
    .NUM_RD   (NR),
    .NUM_WR   (NW),
    .ZERO_REG (ZR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .re            (re),
    .ra            (ra),
    .rd            (rd),
    .we            (we),
    .wa            (wa),
    .wd            (wd),
    .ready         (ready),
    .wr_conflict   (wr_conflict),
    .conflict_addr (conflict_addr)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic int wa_of(input int j);
    return int'(wa[j*AW +: AW]);
  endfunction

  function automatic int ra_of(input int i);
    return int'(ra[i*AW +: AW]);
  endfunction

  function automatic logic [WW-1:0] wd_of(input int j);
    return wd[j*WW +: WW];
  endfunction

  function automatic bit m_ok(input int a);
    return (a < RS) && !(ZR != 0 && a == 0);
  endfunction

  function automatic bit exp_ready();
    return started && (since >= RS);
  endfunction

  // Expected read data: zero unless ready, enabled and usable; otherwise the
  // stored word, replaced by a same-cycle write when bypass is built in.
  function automatic logic [WW-1:0] exp_rd(input int i);
    logic [WW-1:0] v;
    if (!exp_ready() || !re[i] || !m_ok(ra_of(i))) return '0;
    v = mdl[ra_of(i)];
`ifdef REGFILE_BYPASS_EN
    if (!rst) begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && m_ok(wa_of(j)) && wa_of(j) == ra_of(i)) v = wd_of(j);
      end
    end
`endif
    return v;
  endfunction

  function automatic logic [NW*AW-1:0] pa(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [NW*WW-1:0] pd(input int d0, input int d1, input int d2);
    return {WW'(d2), WW'(d1), WW'(d0)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NR-1:0] rev, input logic [NR*AW-1:0] rav,
                               input logic [NW-1:0] wev, input logic [NW*AW-1:0] wav,
                               input logic [NW*WW-1:0] wdv);
    rst = r;
    re  = rev;
    ra  = rav;
    we  = wev;
    wa  = wav;
    wd  = wdv;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model update on each rising edge. Ready follows an edge count
  // since reset release; the whole array is known-zero once the count
  // reaches RF_SIZE. Collisions are found by searching from the highest
  // live port downward for any other live port at the same address.
  always @(posedge clk) begin
    if (rst) begin
      since   = 0;
      m_conf  = 1'b0;
      m_caddr = '0;
      started = 1'b1;
    end else if (since < RS) begin
      since++;
      m_conf = 1'b0;
      if (since == RS) begin
        for (int k = 0; k < RS; k++) mdl[k] = '0;
      end
    end else begin
      c_found = 1'b0;
      c_addr  = 0;
      for (int k = NW - 1; k >= 0 && !c_found; k--) begin
        if (we[k] && m_ok(wa_of(k))) begin
          for (int j = 0; j < NW; j++) begin
            if (j != k && we[j] && wa_of(j) == wa_of(k)) begin
              c_found = 1'b1;
              c_addr  = wa_of(k);
            end
          end
        end
      end
      m_conf = c_found;
      if (c_found) m_caddr = AW'(c_addr);
      for (int j = 0; j < NW; j++) begin
        if (we[j] && m_ok(wa_of(j))) mdl[wa_of(j)] = wd_of(j);
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("ready", 32'(ready), 32'(exp_ready()));
      checkOutput("wr_conflict", 32'(wr_conflict), 32'(m_conf));
      checkOutput("conflict_addr", 32'(conflict_addr), 32'(m_caddr));
      for (int i = 0; i < NR; i++) begin
        checkOutput($sformatf("rd%0d", i), 32'(rd[i*WW +: WW]), 32'(exp_rd(i)));
      end
    end
  end

  // Directed sequences with literal expectations, then random traffic.
  initial begin
    applyStimulus(1'b1, 3'b111, pa(7, 1, 25), '0, '0, '0);
    step(2);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_conf", 32'(wr_conflict), 32'd0);
    checkOutput("rst_caddr", 32'(conflict_addr), 32'd0);
    checkOutput("rst_rd0", 32'(rd[0 +: WW]), 32'd0);

    applyStimulus(1'b0, 3'b111, pa(7, 1, 25), '0, '0, '0);
    for (int k = 1; k <= RS; k++) begin
      step(1);
      if (k == RS - 1) checkOutput("sweep_lo", 32'(ready), 32'd0);
      if (k == RS)     checkOutput("sweep_hi", 32'(ready), 32'd1);
    end
    checkOutput("idle_rd", 32'(rd[0 +: WW]), 32'd0);

    applyStimulus(1'b0, 3'b001, pa(4, 0, 0), 3'b001, pa(4, 0, 0), pd(16'h7777, 0, 0));
    step(1);
    applyStimulus(1'b1, 3'b001, pa(4, 0, 0), '0, '0, '0);
    step(1);
    applyStimulus(1'b0, 3'b001, pa(4, 0, 0), '0, '0, '0);
    step(10);
    applyStimulus(1'b1, 3'b001, pa(4, 0, 0), '0, '0, '0);
    step(1);
    applyStimulus(1'b0, 3'b001, pa(4, 0, 0), '0, '0, '0);
    for (int k = 1; k <= RS; k++) begin
      step(1);
      if (k == RS - 1) checkOutput("resweep_lo", 32'(ready), 32'd0);
      if (k == RS)     checkOutput("resweep_hi", 32'(ready), 32'd1);
    end
    checkOutput("resweep_rd", 32'(rd[0 +: WW]), 32'd0);

    applyStimulus(1'b0, 3'b001, pa(5, 0, 0), 3'b011, pa(5, 5, 0), pd(16'hAAAA, 16'h5555, 0));
    step(1);
    applyStimulus(1'b0, 3'b001, pa(5, 0, 0), '0, '0, '0);
    checkOutput("coll_data", 32'(rd[0 +: WW]), 32'h5555);
    checkOutput("coll_pulse", 32'(wr_conflict), 32'd1);
    checkOutput("coll_addr", 32'(conflict_addr), 32'd5);
    step(1);
    checkOutput("coll_end", 32'(wr_conflict), 32'd0);
    checkOutput("coll_hold", 32'(conflict_addr), 32'd5);

    applyStimulus(1'b0, 3'b000, pa(5, 0, 0), '0, '0, '0);
    checkOutput("re_off", 32'(rd[0 +: WW]), 32'd0);

    applyStimulus(1'b0, 3'b001, pa(25, 0, 0), 3'b011, pa(25, 25, 0), pd(16'hBEEF, 16'hBEEF, 0));
    step(1);
    applyStimulus(1'b0, 3'b001, pa(25, 0, 0), '0, '0, '0);
    checkOutput("oor_rd", 32'(rd[0 +: WW]), 32'd0);
    checkOutput("oor_noconf", 32'(wr_conflict), 32'd0);

    applyStimulus(1'b0, 3'b001, pa(3, 0, 0), 3'b001, pa(3, 0, 0), pd(16'h1234, 0, 0));
`ifdef REGFILE_BYPASS_EN
    checkOutput("byp_same", 32'(rd[0 +: WW]), 32'h1234);
`else
    checkOutput("byp_same", 32'(rd[0 +: WW]), 32'h0000);
`endif
    step(1);
    applyStimulus(1'b0, 3'b001, pa(3, 0, 0), '0, '0, '0);
    checkOutput("byp_after", 32'(rd[0 +: WW]), 32'h1234);

    applyStimulus(1'b0, 3'b001, pa(0, 0, 0), 3'b011, pa(0, 0, 0), pd(16'hFFFF, 16'hFFFF, 0));
    checkOutput("zr_same", 32'(rd[0 +: WW]), 32'd0);
    step(1);
    applyStimulus(1'b0, 3'b001, pa(0, 0, 0), '0, '0, '0);
    checkOutput("zr_rd", 32'(rd[0 +: WW]), 32'd0);
    checkOutput("zr_noconf", 32'(wr_conflict), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      int pool [5] = '{0, 3, 5, 19, 20};
      logic [NR*AW-1:0] rav;
      logic [NW*AW-1:0] wav;
      for (int i = 0; i < NR; i++) rav[i*AW +: AW] = AW'($urandom_range(0, 31));
      for (int j = 0; j < NW; j++) begin
        if ($urandom_range(0, 1) == 0) wav[j*AW +: AW] = AW'(pool[$urandom_range(0, 4)]);
        else                           wav[j*AW +: AW] = AW'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 1) == 0) rav[0 +: AW] = wav[0 +: AW];
      applyStimulus(($urandom_range(0, 199) == 0), NR'($urandom), rav, NW'($urandom), wav,
                    {WW'($urandom), WW'($urandom), WW'($urandom)});
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the fixed 3-read/2-write, 32x32 block. It provides NUM_RD asynchronous read ports and NUM_WR synchronous write ports with deterministic write-collision priority. A sequential clear sweep zeroes every entry after reset, and a registered conflict report is provided. It sits between decode (read addresses) and writeback (write ports) in the datapath.

## Interface
Parameters:
- WORD_W, 32, data width per entry
- RF_SIZE, 32, number of entries (≥2; need not be a power of two)
- NUM_RD, 3, read port count (≥1)
- NUM_WR, 2, write port count (≥1)
- ZERO_REG, 0, when 1 entry 0 is hardwired to zero
- ADDR_W (localparam), $clog2(RF_SIZE)

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- re  in  NUM_RD  per-port read enable
- ra  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*WORD_W  read data, port i at [i*WORD_W +: WORD_W]
- we  in  NUM_WR  per-port write enable
- wa  in  NUM_WR*ADDR_W  write addresses, packed as ra
- wd  in  NUM_WR*WORD_W  write data, packed as rd
- ready  out  1  high once the clear sweep has completed
- wr_conflict  out  1  one-cycle pulse: ≥2 enabled write ports hit the same address in the previous cycle
- conflict_addr  out  ADDR_W  address of the most recent conflict

## Operation
- FSM states: INIT (sweep in progress) and READY.
- rst sampled high: state←INIT, sweep counter←0, wr_conflict←0, conflict_addr←0, ready←0. Array contents are not touched on reset edges.
- INIT: on each edge with rst low, RF[cnt]←0 and cnt←cnt+1. At the edge that clears entry RF_SIZE-1, state←READY.
- INIT behaviour: all write ports are ignored, and every rd reads 0.
- READY: write port j writes RF[wa_j]←wd_j when we_j=1.
- Write collision: when several enabled ports share an address, the highest port index wins. Lower ports to that address are dropped.
- Conflict report: wr_conflict←1 for exactly one cycle when any pair of enabled ports shares an address. conflict_addr←that address; among multiple colliding addresses, the one of the highest-index winning port. conflict_addr holds its value until the next conflict.
- Reads: rd_i = re_i ? RF[ra_i] : 0, combinational.
- Addresses ≥ RF_SIZE: writes are dropped, reads return 0, and no conflict is reported.
- ZERO_REG=1: reads of address 0 return 0, writes to address 0 are dropped, and they do not count as conflicts.
- A reset during INIT restarts the sweep at entry 0. A reset during READY re-enters INIT.

## Timing
- Read latency is 0 cycles (combinational path from ra/re to rd).
- Write latency: data written at edge N is visible on rd after edge N (without bypass).
- ready rises exactly RF_SIZE rising edges after the first edge with rst low, and then stays high until the next rst.
- wr_conflict is asserted in the cycle after the colliding edge.
- Reset values: rd=0 (INIT forces zero), ready=0, wr_conflict=0, conflict_addr=0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read port whose address matches an enabled, in-range write port in the same cycle returns that write data combinationally.
  - If several write ports match, the highest index wins, consistent with write priority.
  - Bypass is inactive in INIT and for the ZERO_REG address 0.
- REGFILE_BYPASS_EN undefined: reads always return array contents before the edge.

## Structure
- Package regfile_pkg holds:
  - the state enum typedef (INIT, READY)
  - default parameter constants (WORD_W, RF_SIZE, NUM_RD, NUM_WR)
- Sub-module regfile_init_seq holds the FSM plus sweep counter. It outputs clr_en, clr_addr and ready.
- Top-level regfile_mp holds the array, write-priority logic, conflict detector and read/bypass muxes.

## Test plan
- Reset then idle (RF_SIZE=32): ready low for 31 edges after rst falls and high at edge 32. Reading any address after ready returns 0.
- Reset mid-sweep: assert rst at sweep cycle 10 for 1 cycle, then release. ready returns exactly 32 edges later and all entries read 0.
- Collision: we=2'b11, wa0=wa1=5, wd0=0xAAAA, wd1=0x5555. Next cycle RF[5] reads 0x5555, wr_conflict pulses for 1 cycle, conflict_addr=5.
- Read enable and range: re_i=0 gives rd_i=0. With RF_SIZE=20, a write to address 25 is dropped and a read of address 25 returns 0.
- Bypass, in the same cycle as a write we0=1, wa0=3, wd0=0x1234 with ra0=3:
  - With REGFILE_BYPASS_EN, rd0=0x1234 immediately.
  - Without it, rd0 holds the old value and shows 0x1234 only after the edge.
- ZERO_REG=1: write 0xFFFF to address 0 → reads return 0 and no wr_conflict is raised.
